full_adder_db: RTL and testbench

One-bit full adder with a debug wrapper. It computes sum and carry combinationally from a, b and a carry-in. Around that core it adds registered copies of the result, a bit-serial carry mode and a truth-table coverage monitor. It sits as a leaf arithmetic cell and exposes its observation state for bring-up and self-check.

---
 rtl/full_adder_db.sv | 70 +++++++
 tb/tb_full_adder_db.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/full_adder_db.sv
// One-bit full adder with debug wrapper: registered result copies, bit-serial
// carry chaining, a truth-table coverage bitmap and a saturating carry counter.
module full_adder_db #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             serial_en,
    input  logic             cov_clr,
    output logic             s,
    output logic             cout,
    output logic             s_q,
    output logic             cout_q,
    output logic             carry_q,
    output logic [7:0]       cov,
    output logic             cov_all,
    output logic [CNT_W-1:0] cout_cnt
);

    logic             cEff;
    logic [2:0]       covIdx;
    logic             carry_d;
    logic [7:0]       cov_d;
    logic [CNT_W-1:0] cnt_d;

    // The adder core stays purely combinational so it behaves as a leaf cell
    always_comb begin
        cEff    = serial_en ? carry_q : cin;
        s       = a ^ b ^ cEff;
        cout    = (a & b) | (a & cEff) | (b & cEff);
        covIdx  = {a, b, cEff};
        cov_all = &cov;
    end

    // Leaving serial mode flushes the carry so the next serial word starts clean
    always_comb begin
        carry_d = serial_en ? cout : 1'b0;
        cov_d   = cov;
        cnt_d   = cout_cnt;
        if (cov_clr) begin
            cov_d = '0;
            cnt_d = '0;
        end else begin
            cov_d[covIdx] = 1'b1;
            if (cout && (cout_cnt != {CNT_W{1'b1}})) begin
                cnt_d = cout_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q      <= 1'b0;
            cout_q   <= 1'b0;
            carry_q  <= 1'b0;
            cov      <= '0;
            cout_cnt <= '0;
        end else begin
            s_q      <= s;
            cout_q   <= cout;
            carry_q  <= carry_d;
            cov      <= cov_d;
            cout_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_full_adder_db.sv
// Self-checking bench for full_adder_db: directed test-plan steps plus a random
// phase, all compared against an arithmetic reference model.
module tb_full_adder_db;

    localparam int CNT_W = 8;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             a, b, cin, serial_en, cov_clr;
    logic             s, cout, s_q, cout_q, carry_q, cov_all;
    logic [7:0]       cov;
    logic [CNT_W-1:0] cout_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state, kept as plain integers and a bit vector
    int       mCarry;
    int       mSq;
    int       mCq;
    bit [7:0] mCov;
    int       mCnt;

    full_adder_db #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
        .serial_en(serial_en), .cov_clr(cov_clr),
        .s(s), .cout(cout), .s_q(s_q), .cout_q(cout_q), .carry_q(carry_q),
        .cov(cov), .cov_all(cov_all), .cout_cnt(cout_cnt)
    );

    always #5 clk = ~clk;

    task automatic doCheck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mCarry = 0; mSq = 0; mCq = 0; mCov = '0; mCnt = 0;
    endtask

    task automatic checkOutput(input string tag);
        doCheck({tag, ".s_q"},      s_q,      mSq);
        doCheck({tag, ".cout_q"},   cout_q,   mCq);
        doCheck({tag, ".carry_q"},  carry_q,  mCarry);
        doCheck({tag, ".cov"},      cov,      mCov);
        doCheck({tag, ".cov_all"},  cov_all,  (mCov == 8'hFF));
        doCheck({tag, ".cout_cnt"}, cout_cnt, mCnt);
    endtask

    // Drive one vector, check the combinational result, clock it, check state
    task automatic applyStimulus(input string tag, input int ia, input int ib, input int ic,
                                 input int isen, input int iclr);
        int cE, total;
        a = ia[0]; b = ib[0]; cin = ic[0]; serial_en = isen[0]; cov_clr = iclr[0];
        #1;
        cE    = isen ? mCarry : ic;
        total = ia + ib + cE;
        doCheck({tag, ".s"},    s,    total % 2);
        doCheck({tag, ".cout"}, cout, total / 2);
        @(posedge clk);
        mSq    = total % 2;
        mCq    = total / 2;
        mCarry = isen ? total / 2 : 0;
        if (iclr != 0) begin
            mCov = '0;
            mCnt = 0;
        end else begin
            mCov[ia * 4 + ib * 2 + cE] = 1'b1;
            if (total >= 2 && mCnt < SAT) mCnt++;
        end
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [7:0] expS;
        logic [7:0] expC;
        logic [3:0] serA;
        logic [3:0] serB;
        logic [3:0] serS;
        expS = 8'b1001_0110;
        expC = 8'b1110_1000;
        serA = 4'b1011;
        serB = 4'b0110;
        serS = 4'b0001;

        rst = 1'b1; a = 0; b = 0; cin = 0; serial_en = 0; cov_clr = 0;
        modelReset();
        #3;
        checkOutput("reset");

        @(negedge clk);
        rst = 1'b0;

        // Exhaustive truth table, clocked one vector per cycle
        for (int i = 0; i < 8; i++) begin
            a = i[2]; b = i[1]; cin = i[0]; serial_en = 0; cov_clr = 0;
            #1;
            doCheck("truth.s",    s,    expS[i]);
            doCheck("truth.cout", cout, expC[i]);
            applyStimulus("truth", i / 4, (i / 2) % 2, i % 2, 0, 0);
        end
        doCheck("truth.cov_ff",  cov,      8'hFF);
        doCheck("truth.cov_all", cov_all,  1'b1);
        doCheck("truth.cnt4",    cout_cnt, 4);

        // Serial 11 + 6, LSB first
        for (int i = 0; i < 4; i++) begin
            a = serA[i]; b = serB[i]; serial_en = 1; cov_clr = 0;
            #1;
            doCheck("serial.s_const", s, serS[i]);
            applyStimulus("serial", serA[i], serB[i], 0, 1, 0);
        end
        doCheck("serial.carry_final", carry_q, 1'b1);

        // Randomised phase
        for (int i = 0; i < 60; i++) begin
            applyStimulus("rand", $urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 1), $urandom_range(0, 1),
                          ($urandom_range(0, 7) == 0) ? 1 : 0);
        end

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            applyStimulus("sat", 1, 1, 0, 0, 0);
        end
        doCheck("sat.cnt255", cout_cnt, SAT);

        // Clear priority over simultaneous set/increment
        for (int i = 0; i < 8; i++) begin
            applyStimulus("refill", i / 4, (i / 2) % 2, i % 2, 0, 0);
        end
        doCheck("clr.pre_ff", cov, 8'hFF);
        applyStimulus("clr", 1, 1, 1, 0, 1);
        doCheck("clr.cov0", cov,      8'h00);
        doCheck("clr.cnt0", cout_cnt, 0);
        applyStimulus("post_clr", 1, 1, 1, 0, 0);
        doCheck("post_clr.cov80", cov,      8'h80);
        doCheck("post_clr.cnt1",  cout_cnt, 1);

        // Async reset in the middle of a serial word
        applyStimulus("pre_rst", 1, 1, 0, 1, 0);
        doCheck("pre_rst.carry1", carry_q, 1'b1);
        a = 1; b = 0; serial_en = 1; cov_clr = 0;
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("async_rst");
        doCheck("async_rst.s",    s,    1'b1);
        doCheck("async_rst.cout", cout, 1'b0);
        a = 1; b = 1;
        #1;
        doCheck("async_rst.s11",    s,    1'b0);
        doCheck("async_rst.cout11", cout, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("after_rst", 1, 0, 0, 1, 0);
        doCheck("after_rst.carry0", carry_q, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
